// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: steps a 4-input network through all 16 minterms,
// captures its output per minterm and compares against an expected table.
module tt_sweep_capture #(
    parameter int unsigned SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp_tt,
    output logic [3:0]  x,
    input  logic        y_in,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] tt,
    output logic        match
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        HOLD
    } state_t;

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [15:0] exp_q;
    logic        sample;
    logic        last;
    logic [15:0] tt_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // sample fires on the final cycle of each minterm's settle window
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                sample = (wait_cnt == SETTLE_W);
                last   = sample && (x == 4'hF);
                if (last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // match is evaluated on the final sample edge, so bit 15 comes straight from y_in
    always_comb begin
        tt_full     = tt;
        tt_full[15] = y_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= 4'h0;
            wait_cnt <= 4'h0;
            exp_q    <= 16'h0000;
            tt       <= 16'h0000;
            match    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q    <= exp_tt;
                        x        <= 4'h0;
                        wait_cnt <= 4'h0;
                        tt       <= 16'h0000;
                    end
                end
                SWEEP: begin
                    if (sample) begin
                        tt[x]    <= y_in;
                        wait_cnt <= 4'h0;
                        if (last) begin
                            x     <= 4'h0;
                            match <= (tt_full == exp_q);
                        end else begin
                            x <= x + 4'h1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'h1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == SWEEP);
    assign res_valid = (state == HOLD);

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 0: extra wait cycles per minterm before sampling (range 0..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request one 16-minterm sweep.
REQ-005 SHALL have port exp_tt, input, 16: expected truth table; bit i = expected output for minterm i.
REQ-006 SHALL have port x, output, 4: registered stimulus to the 4-input gate network under test; x[0] drives x0 ... x[3] drives x3.
REQ-007 SHALL have port y_in, input, 1: combinational output y0 of the network under test.
REQ-008 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-009 SHALL have port res_valid, output, 1: result available.
REQ-010 SHALL have port res_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port tt, output, 16: captured truth table; bit i = y_in sampled while x == i.
REQ-012 SHALL have port match, output, 1: tt equals the captured exp_tt.

Function
REQ-013 SHALL implement FSM states IDLE, SWEEP, HOLD (result pending).
REQ-014 In IDLE, start=1 SHALL move to SWEEP on that edge, capture exp_tt into an internal register, set x=0, clear the wait counter, and clear tt.
REQ-015 start SHALL be ignored in SWEEP and HOLD; exp_tt changes after capture SHALL NOT affect match.
REQ-016 In SWEEP, each minterm SHALL be presented on x for exactly 1+SETTLE cycles; y_in SHALL be sampled into tt[x] on the last edge of that window.
REQ-017 After the sample for minterm i<15, x SHALL advance to i+1 on the same edge; after the sample for minterm 15, FSM SHALL go to HOLD and x SHALL return to 0.
REQ-018 A sweep SHALL last exactly 16*(1+SETTLE) cycles from the first cycle with busy=1 to the first cycle with res_valid=1.
REQ-019 busy SHALL be 1 exactly in SWEEP; res_valid SHALL be 1 exactly in HOLD.
REQ-020 match SHALL be registered, computed from the complete tt, and valid whenever res_valid=1.
REQ-021 tt and match SHALL stay stable while res_valid=1 and res_ready=0.
REQ-022 In HOLD, res_ready=1 SHALL return FSM to IDLE on that edge; res_valid SHALL fall next cycle; tt/match SHALL retain last values until the next start.
REQ-023 A start asserted in the same cycle as the HOLD->IDLE handshake SHALL be ignored; a new sweep requires start in IDLE.
REQ-024 x SHALL be 0 whenever the FSM is not in SWEEP.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force FSM=IDLE, x=0, tt=0, match=0, busy=0, res_valid=0, captured exp_tt=0, wait counter=0.
REQ-026 rst asserted mid-sweep or in HOLD SHALL abort the operation with no partial result presented; first start after rst release SHALL run a full sweep from x=0.

Verification
REQ-027 SETTLE=0, y_in=x[0], exp_tt=16'hAAAA, start pulse -> x steps 0..15 one per cycle, res_valid after 16 cycles, tt=16'hAAAA, match=1.
REQ-028 SETTLE=0, y_in=majority(x[0],x[1],x[3]), exp_tt=16'hAAAA -> tt=16'hEE88, match=0.
REQ-029 SETTLE=2, y_in=x[3], exp_tt=16'hFF00 -> each x value held 3 cycles, res_valid after 48 cycles, tt=16'hFF00, match=1.
REQ-030 res_ready held 0 for 10 cycles in HOLD, start pulsed meanwhile -> res_valid, tt, match unchanged, no new sweep; res_ready=1 -> IDLE, res_valid=0 next cycle.
REQ-031 rst asserted at x=7 in SWEEP -> busy=0, x=0, tt=0 asynchronously; subsequent start with y_in=1, exp_tt=16'hFFFF -> tt=16'hFFFF, match=1.
REQ-032 exp_tt changed from 16'hAAAA to 16'h0000 one cycle after start, y_in=x[0] -> match=1.
